// File: rtl/pipe_stage_regs_if.sv
// Bundle of the hazard-control inputs, fetch/decode datapath inputs and the
// registered PC, IF/ID and ID/EX outputs of pipe_stage_regs.
// master: the surrounding pipeline (drives controls and operands).
// slave:  the stage-register block itself.
interface pipe_stage_regs_if #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 12
);
  logic                  f_stall;
  logic                  d_stall;
  logic                  d_flush;
  logic                  e_flush;
  logic [WIDTH-1:0]      f_pc_next;
  logic [WIDTH-1:0]      f_pc;
  logic [WIDTH-1:0]      f_instr;
  logic [WIDTH-1:0]      f_pc_plus4;
  logic [WIDTH-1:0]      d_instr;
  logic [WIDTH-1:0]      d_pc_plus4;
  logic                  d_valid;
  logic [WIDTH-1:0]      d_rd0;
  logic [WIDTH-1:0]      d_rd1;
  logic [WIDTH-1:0]      d_imm;
  logic [4:0]            d_rs;
  logic [4:0]            d_rt;
  logic [4:0]            d_rd;
  logic [CTRL_WIDTH-1:0] d_ctrl;
  logic [WIDTH-1:0]      e_rd0;
  logic [WIDTH-1:0]      e_rd1;
  logic [WIDTH-1:0]      e_imm;
  logic [4:0]            e_rs;
  logic [4:0]            e_rt;
  logic [4:0]            e_rd;
  logic [CTRL_WIDTH-1:0] e_ctrl;
  logic                  e_valid;

  modport master (
    output f_stall, d_stall, d_flush, e_flush,
    output f_pc_next, f_instr, f_pc_plus4,
    output d_rd0, d_rd1, d_imm, d_rs, d_rt, d_rd, d_ctrl,
    input  f_pc, d_instr, d_pc_plus4, d_valid,
    input  e_rd0, e_rd1, e_imm, e_rs, e_rt, e_rd, e_ctrl, e_valid
  );

  modport slave (
    input  f_stall, d_stall, d_flush, e_flush,
    input  f_pc_next, f_instr, f_pc_plus4,
    input  d_rd0, d_rd1, d_imm, d_rs, d_rt, d_rd, d_ctrl,
    output f_pc, d_instr, d_pc_plus4, d_valid,
    output e_rd0, e_rd1, e_imm, e_rs, e_rt, e_rd, e_ctrl, e_valid
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC register, IF/ID and ID/EX pipeline registers with freeze, flush and
// bubble insertion driven by the hazard unit. Every stage carries a valid bit
// so bubbles can be told apart from real instructions.
// Optional macro PIPE_STAGE_PERF_CNT_EN adds saturating stall_cycles and
// bubble_count counters as extra output ports.
module pipe_stage_regs #(
  parameter int               WIDTH      = 32,
  parameter int               CTRL_WIDTH = 12,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int               CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_regs_if.slave     bus
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] bubble_count
`endif
);

  logic [WIDTH-1:0]      pc_q, pc_d;
  logic [WIDTH-1:0]      d_instr_q, d_instr_d;
  logic [WIDTH-1:0]      d_pc_plus4_q, d_pc_plus4_d;
  logic                  d_valid_q, d_valid_d;
  logic [WIDTH-1:0]      e_rd0_q, e_rd0_d;
  logic [WIDTH-1:0]      e_rd1_q, e_rd1_d;
  logic [WIDTH-1:0]      e_imm_q, e_imm_d;
  logic [4:0]            e_rs_q, e_rs_d;
  logic [4:0]            e_rt_q, e_rt_d;
  logic [4:0]            e_rd_q, e_rd_d;
  logic [CTRL_WIDTH-1:0] e_ctrl_q, e_ctrl_d;
  logic                  e_valid_q, e_valid_d;

  // PC: hold while fetch is frozen, otherwise follow the PC mux
  always_comb begin
    pc_d = bus.f_stall ? pc_q : bus.f_pc_next;
  end

  // IF/ID: stall beats flush (a branch resolved under stall is re-flushed later)
  always_comb begin
    d_instr_d    = d_instr_q;
    d_pc_plus4_d = d_pc_plus4_q;
    d_valid_d    = d_valid_q;
    if (!bus.d_stall) begin
      if (bus.d_flush) begin
        d_instr_d    = '0;
        d_pc_plus4_d = '0;
        d_valid_d    = 1'b0;
      end else begin
        d_instr_d    = bus.f_instr;
        d_pc_plus4_d = bus.f_pc_plus4;
        d_valid_d    = 1'b1;
      end
    end
  end

  // ID/EX: bubbles carry zero indices and zero control so they have no side effects
  always_comb begin
    e_rd0_d   = '0;
    e_rd1_d   = '0;
    e_imm_d   = '0;
    e_rs_d    = '0;
    e_rt_d    = '0;
    e_rd_d    = '0;
    e_ctrl_d  = '0;
    e_valid_d = 1'b0;
    if (!bus.e_flush) begin
      e_rd0_d   = bus.d_rd0;
      e_rd1_d   = bus.d_rd1;
      e_imm_d   = bus.d_imm;
      e_rs_d    = bus.d_rs;
      e_rt_d    = bus.d_rt;
      e_rd_d    = bus.d_rd;
      e_ctrl_d  = d_valid_q ? bus.d_ctrl : '0;
      e_valid_d = d_valid_q;
    end
  end

  // State update; reset overrides any concurrent stall or flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      d_instr_q    <= '0;
      d_pc_plus4_q <= '0;
      d_valid_q    <= 1'b0;
      e_rd0_q      <= '0;
      e_rd1_q      <= '0;
      e_imm_q      <= '0;
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_rd_q       <= '0;
      e_ctrl_q     <= '0;
      e_valid_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      d_instr_q    <= d_instr_d;
      d_pc_plus4_q <= d_pc_plus4_d;
      d_valid_q    <= d_valid_d;
      e_rd0_q      <= e_rd0_d;
      e_rd1_q      <= e_rd1_d;
      e_imm_q      <= e_imm_d;
      e_rs_q       <= e_rs_d;
      e_rt_q       <= e_rt_d;
      e_rd_q       <= e_rd_d;
      e_ctrl_q     <= e_ctrl_d;
      e_valid_q    <= e_valid_d;
    end
  end

  assign bus.f_pc       = pc_q;
  assign bus.d_instr    = d_instr_q;
  assign bus.d_pc_plus4 = d_pc_plus4_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.e_rd0      = e_rd0_q;
  assign bus.e_rd1      = e_rd1_q;
  assign bus.e_imm      = e_imm_q;
  assign bus.e_rs       = e_rs_q;
  assign bus.e_rt       = e_rt_q;
  assign bus.e_rd       = e_rd_q;
  assign bus.e_ctrl     = e_ctrl_q;
  assign bus.e_valid    = e_valid_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] bubble_count_q, bubble_count_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Counters: a bubble is either an EX flush or an unstalled decode flush
  always_comb begin
    stall_cycles_d = bus.f_stall ? sat_inc(stall_cycles_q) : stall_cycles_q;
    bubble_count_d = (bus.e_flush || (bus.d_flush && !bus.d_stall)) ?
                     sat_inc(bubble_count_q) : bubble_count_q;
  end

  // Counter state update
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule
